// File: rtl/mips_exec_controller.sv
// Execution sequencer for the single-cycle MIPS core: gates every architectural
// update through cpu_en and provides run / step / pause / breakpoint / halt control.
`timescale 1ns/1ps
module mips_exec_controller #(
  parameter logic [31:0] HALT_INSTR  = 32'h0000000C,
  parameter int unsigned INIT_CYCLES = 4,
  parameter logic [31:0] MAX_CYCLES  = 32'd0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        cpu_rst,
  output logic        cpu_en,
  output logic [2:0]  state,
  output logic        bp_hit,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_PAUSE = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  init_cnt_q, init_cnt_d;
  logic        run_lvl_q, run_lvl_d, run_prev_q, run_prev_d;
  logic        step_lvl_q, step_lvl_d, step_prev_q, step_prev_d;
  logic        skip_bp_q, skip_bp_d;
  logic        bp_hit_q, bp_hit_d;
  logic [31:0] budget_q, budget_d;
  logic [31:0] retired_q, retired_d;
  logic        cpu_rst_q, cpu_rst_d;

  logic run_edge, step_edge;
  logic is_halt, bp_match, budget_done, run_stop;

  // Requests are registered before edge detection, so a request seen at edge N
  // changes state at edge N+1.
  assign run_edge    = run_lvl_q & ~run_prev_q;
  assign step_edge   = step_lvl_q & ~step_prev_q;
  assign is_halt     = (instr == HALT_INSTR);
  assign bp_match    = bp_en && (pc == bp_addr) && !skip_bp_q;
  assign budget_done = (MAX_CYCLES != 32'd0) && (budget_q == MAX_CYCLES);
  assign run_stop    = is_halt || halt_req || bp_match || budget_done;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_INIT;
      init_cnt_q  <= INIT_LOAD;
      run_lvl_q   <= 1'b1;
      run_prev_q  <= 1'b1;
      step_lvl_q  <= 1'b1;
      step_prev_q <= 1'b1;
      skip_bp_q   <= 1'b0;
      bp_hit_q    <= 1'b0;
      budget_q    <= 32'd0;
      retired_q   <= 32'd0;
      cpu_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      run_lvl_q   <= run_lvl_d;
      run_prev_q  <= run_prev_d;
      step_lvl_q  <= step_lvl_d;
      step_prev_q <= step_prev_d;
      skip_bp_q   <= skip_bp_d;
      bp_hit_q    <= bp_hit_d;
      budget_q    <= budget_d;
      retired_q   <= retired_d;
      cpu_rst_q   <= cpu_rst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    run_lvl_d   = run_req;
    run_prev_d  = run_lvl_q;
    step_lvl_d  = step_req;
    step_prev_d = step_lvl_q;
    skip_bp_d   = skip_bp_q;
    bp_hit_d    = bp_hit_q;
    budget_d    = budget_q;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == 4'd0) state_d = S_PAUSE;
        else                    init_cnt_d = init_cnt_q - 4'd1;
      end
      S_PAUSE: begin
        if (!halt_req) begin
          if (step_edge) begin
            state_d  = S_STEP;
            bp_hit_d = 1'b0;
            budget_d = 32'd0;
          end else if (run_edge) begin
            state_d   = S_RUN;
            bp_hit_d  = 1'b0;
            budget_d  = 32'd0;
            skip_bp_d = 1'b1;
          end
        end
      end
      S_STEP: state_d = is_halt ? S_HALT : S_PAUSE;
      S_RUN: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (halt_req) begin
          state_d = S_PAUSE;
        end else if (bp_match) begin
          state_d  = S_PAUSE;
          bp_hit_d = 1'b1;
        end else if (budget_done) begin
          state_d = S_PAUSE;
        end else begin
          budget_d  = budget_q + 32'd1;
          skip_bp_d = 1'b0;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
    retired_d = (cpu_en && retired_q != 32'hFFFF_FFFF) ? retired_q + 32'd1 : retired_q;
    cpu_rst_d = (state_d == S_INIT);
  end

  // The instruction at pc is only executed when no stop condition fires this cycle.
  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      S_STEP:  cpu_en = !is_halt;
      S_RUN:   cpu_en = !run_stop;
      default: cpu_en = 1'b0;
    endcase
  end

  assign cpu_rst = cpu_rst_q;
  assign state   = state_q;
  assign bp_hit  = bp_hit_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mips_exec_controller.sv
// Directed bench for mips_exec_controller: two instances (unlimited run and a
// 5-instruction budget), each driven by a tiny PC/instruction-memory core model.
`timescale 1ns/1ps
module tb_mips_exec_controller;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam logic [31:0] NOP_W = 32'h2008_0001;
  localparam logic [31:0] HALT  = 32'h0000_000C;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset, run_req, step_req, halt_req, bp_en;
  logic [31:0] bp_addr;
  logic [31:0] imem [0:63];

  logic [31:0] pc_a, instr_a, retired_a, pc_b, instr_b, retired_b;
  logic        cpu_rst_a, cpu_en_a, bp_hit_a, cpu_rst_b, cpu_en_b, bp_hit_b;
  logic [2:0]  state_a, state_b;

  int checks = 0;
  int errors = 0;
  int en_cnt;
  int rst_cnt;

  mips_exec_controller #(.HALT_INSTR(HALT), .INIT_CYCLES(4), .MAX_CYCLES(32'd0)) dut_a (
    .CLOCK_50(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc_a), .instr(instr_a),
    .cpu_rst(cpu_rst_a), .cpu_en(cpu_en_a), .state(state_a), .bp_hit(bp_hit_a),
    .retired(retired_a));

  mips_exec_controller #(.HALT_INSTR(HALT), .INIT_CYCLES(4), .MAX_CYCLES(32'd5)) dut_b (
    .CLOCK_50(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .bp_en(1'b0), .bp_addr(bp_addr), .pc(pc_b), .instr(instr_b),
    .cpu_rst(cpu_rst_b), .cpu_en(cpu_en_b), .state(state_b), .bp_hit(bp_hit_b),
    .retired(retired_b));

  // Core model: pc restarts on cpu_rst and advances by 4 on every enabled cycle.
  always @(posedge clk) begin
    if (cpu_rst_a) pc_a <= BASE;
    else if (cpu_en_a) pc_a <= pc_a + 32'd4;
    if (cpu_rst_b) pc_b <= BASE;
    else if (cpu_en_b) pc_b <= pc_b + 32'd4;
  end
  assign instr_a = imem[pc_a[7:2]];
  assign instr_b = imem[pc_b[7:2]];

  task automatic do_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0;
    bp_en = 1'b0; bp_addr = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (state_a !== 3'd0 || cpu_rst_a !== 1'b1 || cpu_en_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: state=%0d cpu_rst=%b cpu_en=%b, want 0/1/0", state_a, cpu_rst_a, cpu_en_a);
    end
    checks++;
    if (retired_a !== 32'd0 || bp_hit_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_counters: retired=%0d bp_hit=%b, want 0/0", retired_a, bp_hit_a);
    end
    reset = 1'b0;
    rst_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_rst_a === 1'b1) rst_cnt++;
      @(negedge clk);
    end
    checks++;
    if (rst_cnt !== 4) begin
      errors++;
      $display("FAIL init_length: cpu_rst high %0d cycles, want 4", rst_cnt);
    end
    checks++;
    if (state_a !== 3'd1 || cpu_en_a !== 1'b0 || retired_a !== 32'd0 || pc_a !== BASE) begin
      errors++;
      $display("FAIL init_to_pause: state=%0d cpu_en=%b retired=%0d pc=%h, want 1/0/0/%h",
               state_a, cpu_en_a, retired_a, pc_a, BASE);
    end
    $display("test_reset: cpu_rst cycles=%0d state=%0d", rst_cnt, state_a);
  endtask

  task automatic test_step;
    for (int k = 0; k < 3; k++) begin
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      checks++;
      if (state_a !== 3'd1 || cpu_en_a !== 1'b0) begin
        errors++;
        $display("FAIL step_latency[%0d]: state=%0d cpu_en=%b, want 1/0", k, state_a, cpu_en_a);
      end
      @(negedge clk);
      if (k == 2) halt_req = 1'b1;
      #1;
      checks++;
      if (state_a !== 3'd3 || cpu_en_a !== 1'b1) begin
        errors++;
        $display("FAIL step_enable[%0d]: state=%0d cpu_en=%b, want 3/1", k, state_a, cpu_en_a);
      end
      @(negedge clk);
      halt_req = 1'b0;
      checks++;
      if (state_a !== 3'd1 || cpu_en_a !== 1'b0 || retired_a !== 32'(k + 1)) begin
        errors++;
        $display("FAIL step_done[%0d]: state=%0d cpu_en=%b retired=%0d, want 1/0/%0d",
                 k, state_a, cpu_en_a, retired_a, k + 1);
      end
      $display("test_step: step %0d retired=%0d pc=%h", k, retired_a, pc_a);
    end
    checks++;
    if (pc_a !== BASE + 32'd12) begin
      errors++;
      $display("FAIL step_pc: pc=%h, want %h", pc_a, BASE + 32'd12);
    end
  endtask

  task automatic test_breakpoint;
    do_reset();
    bp_en = 1'b1; bp_addr = BASE + 32'hC;
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    @(negedge clk);
    checks++;
    if (state_a !== 3'd2 || cpu_en_a !== 1'b1 || pc_a !== BASE) begin
      errors++;
      $display("FAIL run_start: state=%0d cpu_en=%b pc=%h, want 2/1/%h", state_a, cpu_en_a, pc_a, BASE);
    end
    en_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (cpu_en_a === 1'b1) en_cnt++;
      @(negedge clk);
    end
    checks++;
    if (en_cnt !== 3 || state_a !== 3'd1 || bp_hit_a !== 1'b1 || retired_a !== 32'd3 || pc_a !== BASE + 32'hC) begin
      errors++;
      $display("FAIL bp_stop: en=%0d state=%0d bp_hit=%b retired=%0d pc=%h, want 3/1/1/3/%h",
               en_cnt, state_a, bp_hit_a, retired_a, pc_a, BASE + 32'hC);
    end
    $display("test_breakpoint: stopped pc=%h retired=%0d", pc_a, retired_a);
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    @(negedge clk);
    checks++;
    if (state_a !== 3'd2 || cpu_en_a !== 1'b1 || pc_a !== BASE + 32'hC || bp_hit_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_resume: state=%0d cpu_en=%b pc=%h bp_hit=%b, want 2/1/%h/0",
               state_a, cpu_en_a, pc_a, bp_hit_a, BASE + 32'hC);
    end
    @(negedge clk);
    checks++;
    if (pc_a !== BASE + 32'h10 || retired_a !== 32'd4 || cpu_en_a !== 1'b1) begin
      errors++;
      $display("FAIL bp_continue: pc=%h retired=%0d cpu_en=%b, want %h/4/1",
               pc_a, retired_a, cpu_en_a, BASE + 32'h10);
    end
    halt_req = 1'b1;
    #1;
    checks++;
    if (cpu_en_a !== 1'b0) begin
      errors++;
      $display("FAIL halt_req_stop_cycle: cpu_en=%b, want 0", cpu_en_a);
    end
    @(negedge clk);
    halt_req = 1'b0;
    checks++;
    if (state_a !== 3'd1 || retired_a !== 32'd4 || pc_a !== BASE + 32'h10) begin
      errors++;
      $display("FAIL halt_req_pause: state=%0d retired=%0d pc=%h, want 1/4/%h",
               state_a, retired_a, pc_a, BASE + 32'h10);
    end
    bp_en = 1'b0;
    $display("test_breakpoint: resumed and paused at pc=%h retired=%0d", pc_a, retired_a);
  endtask

  task automatic test_halt_instr;
    do_reset();
    imem[2] = HALT;
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pc_a !== BASE + 32'h8 || state_a !== 3'd2 || cpu_en_a !== 1'b0) begin
      errors++;
      $display("FAIL halt_cycle: pc=%h state=%0d cpu_en=%b, want %h/2/0", pc_a, state_a, cpu_en_a, BASE + 32'h8);
    end
    @(negedge clk);
    checks++;
    if (state_a !== 3'd4 || retired_a !== 32'd2) begin
      errors++;
      $display("FAIL halt_state: state=%0d retired=%0d, want 4/2", state_a, retired_a);
    end
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (state_a !== 3'd4 || retired_a !== 32'd2 || cpu_en_a !== 1'b0) begin
      errors++;
      $display("FAIL halt_sticky: state=%0d retired=%0d cpu_en=%b, want 4/2/0", state_a, retired_a, cpu_en_a);
    end
    do_reset();
    imem[2] = NOP_W;
    checks++;
    if (state_a !== 3'd1 || retired_a !== 32'd0) begin
      errors++;
      $display("FAIL halt_reset_exit: state=%0d retired=%0d, want 1/0", state_a, retired_a);
    end
    $display("test_halt_instr: halted then reset, state=%0d", state_a);
  endtask

  task automatic test_budget;
    do_reset();
    for (int r = 1; r <= 2; r++) begin
      run_req = 1'b1;
      @(negedge clk);
      run_req = 1'b0;
      @(negedge clk);
      en_cnt = 0;
      for (int i = 0; i < 10; i++) begin
        if (cpu_en_b === 1'b1) en_cnt++;
        @(negedge clk);
      end
      checks++;
      if (en_cnt !== 5 || state_b !== 3'd1 || retired_b !== 32'(5 * r) || pc_b !== BASE + 32'(20 * r)) begin
        errors++;
        $display("FAIL budget_run[%0d]: en=%0d state=%0d retired=%0d pc=%h, want 5/1/%0d/%h",
                 r, en_cnt, state_b, retired_b, pc_b, 5 * r, BASE + 32'(20 * r));
      end
      halt_req = 1'b1;
      @(negedge clk);
      halt_req = 1'b0;
      checks++;
      if (state_a !== 3'd1) begin
        errors++;
        $display("FAIL budget_free_pause[%0d]: state=%0d, want 1", r, state_a);
      end
      $display("test_budget: run %0d retired=%0d", r, retired_b);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    run_req = 1'b1; step_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0; step_req = 1'b0;
    @(negedge clk);
    checks++;
    if (state_a !== 3'd3 || cpu_en_a !== 1'b1) begin
      errors++;
      $display("FAIL both_edges_step: state=%0d cpu_en=%b, want 3/1", state_a, cpu_en_a);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (state_a !== 3'd1 || retired_a !== 32'd1) begin
      errors++;
      $display("FAIL both_edges_done: state=%0d retired=%0d, want 1/1", state_a, retired_a);
    end
    $display("test_back_to_back: retired=%0d", retired_a);
  endtask

  task automatic test_run_across_reset;
    run_req = 1'b1;
    do_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (state_a !== 3'd1 || retired_a !== 32'd0 || cpu_en_a !== 1'b0) begin
      errors++;
      $display("FAIL run_held_reset: state=%0d retired=%0d cpu_en=%b, want 1/0/0", state_a, retired_a, cpu_en_a);
    end
    run_req = 1'b0;
    $display("test_run_across_reset: state=%0d", state_a);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = NOP_W;
    test_reset();
    test_step();
    test_breakpoint();
    test_halt_instr();
    test_budget();
    test_back_to_back();
    test_run_across_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_exec_controller.md
# mips_exec_controller

Execution sequencer for the single-cycle MIPS core on the DE2 board. Sits between the board controls (debounced KEY/SW levels) and the processor, gating every architectural state update (PC, register file, data memory writes) through one enable. Provides run, single-step, pause, PC breakpoint, halt-instruction detection and an optional cycle budget, plus a retired-instruction counter for the HEX/LED debug outputs.

## Interface
- HALT_INSTR, 32'h0000000C, instruction word (syscall) that permanently halts the core
- INIT_CYCLES, 4, cycles cpu_rst is held after reset (1..15)
- MAX_CYCLES, 0, retired-instruction budget per run; 0 disables
- CLOCK_50  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; resets controller and asserts cpu_rst
- run_req  in  1  level; rising edge requests free-run
- step_req  in  1  level; rising edge requests one instruction
- halt_req  in  1  level; while high, forces pause from RUN
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC
- pc  in  32  current PC from core
- instr  in  32  instruction word at pc from instruction memory
- cpu_rst  out  1  core reset (PC to start of instruction memory)
- cpu_en  out  1  core state-update enable (combinational)
- state  out  3  0=INIT 1=PAUSE 2=RUN 3=STEP 4=HALT
- bp_hit  out  1  sticky: last stop was a breakpoint
- retired  out  32  instructions executed since reset

## Operation
- Edge detect: run_req/step_req registered each cycle; edge = level & ~prev. prev regs reset to 1 (a level already high at reset is not an edge).
- INIT: cpu_rst=1, cpu_en=0; down-counter loaded with INIT_CYCLES-1 on reset; at 0 -> PAUSE.
- PAUSE: cpu_en=0. Priority: halt_req high -> stay; step edge -> STEP; run edge -> RUN (step wins if both). Entering RUN or STEP clears bp_hit and the budget counter; entering RUN sets skip_bp=1.
- STEP: if instr==HALT_INSTR -> HALT with cpu_en=0; else cpu_en=1 for exactly this cycle, retired++, -> PAUSE. Breakpoints ignored in STEP.
- RUN: stop conditions evaluated on current pc/instr, priority order: instr==HALT_INSTR -> HALT; halt_req -> PAUSE; bp_en & pc==bp_addr & ~skip_bp -> PAUSE, bp_hit=1; MAX_CYCLES!=0 & budget==MAX_CYCLES -> PAUSE. When any stop fires, cpu_en=0 that cycle (instruction at pc not executed). Otherwise cpu_en=1, retired++, budget++, skip_bp cleared.
- HALT: cpu_en=0; only reset exits. run/step edges ignored.
- retired saturates at 32'hFFFFFFFF; budget is 32-bit, compared only when MAX_CYCLES!=0.

## Timing
- Reset values: state=INIT, cpu_rst=1, cpu_en=0, bp_hit=0, retired=0, skip_bp=0, budget=0.
- cpu_rst registered, falls on the edge that enters PAUSE (INIT_CYCLES cycles after reset deasserts).
- Req edge at cycle N (level seen high at edge N, low at N-1) -> state changes at edge N+1; cpu_en first high during cycle N+1.
- cpu_en is combinational from state, pc, instr, halt_req, bp regs; core consumes it on the same edge that advances pc.
- Resume from breakpoint: first RUN cycle executes instruction at bp_addr without re-trapping; subsequent arrival at bp_addr traps.
- Reset mid-RUN/STEP: cpu_en drops in the reset cycle's following state (INIT), no partial step; retired cleared.
- halt_req high during STEP does not cancel the step.

## Test plan
- Reset, INIT_CYCLES=4: cpu_rst high exactly 4 cycles after reset low, state=1, cpu_en=0, retired=0.
- Three step_req pulses in PAUSE with non-halt instr -> exactly 3 single-cycle cpu_en pulses, retired=3, state returns to 1 after each.
- run_req, bp_en=1, bp_addr=0x0040000C, pc advancing by 4 from 0x00400000 -> cpu_en high for 3 cycles, stops at pc=0x0040000C with bp_hit=1, retired=3; second run_req executes 0x0040000C (retired=4) and continues.
- RUN reaching instr=0x0000000C -> cpu_en=0 that cycle, state=4; later run/step edges leave state=4, retired unchanged until reset.
- MAX_CYCLES=5, run_req -> retired increments by 5 then state=1; halt_req asserted mid-run -> pause next cycle with cpu_en=0 in stop cycle.
- run_req and step_req rising in same cycle -> STEP taken, retired +1, state back to 1; run_req held high across reset produces no run.
